// File: rtl/cpu64_l2_probe_sched.sv
// Probe scheduler for the L2 coherence controller: issues one B-channel Probe per targeted
// core in ascending core-ID order and collects the C-channel acks, with an ack watchdog.
module cpu64_l2_probe_sched #(
   parameter  int CORES     = 4,
   parameter  int ADDR_W    = 64,
   parameter  int TIMEOUT_W = 10,
   localparam int CID_W     = (CORES > 1) ? $clog2(CORES) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [CORES-1:0]  start_mask_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [1:0]        start_param_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic              any_dirty_o,
   output logic              err_o,
   output logic [CORES-1:0]  pending_o,
   output logic [2:0]        b_opcode_o,
   output logic [1:0]        b_param_o,
   output logic [ADDR_W-1:0] b_address_o,
   output logic [CID_W-1:0]  b_dest_o,
   output logic              b_valid_o,
   input  logic              b_ready_i,
   input  logic              ack_valid_i,
   input  logic [CID_W-1:0]  ack_id_i,
   input  logic              ack_data_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_DONE
   } state_t;

   state_t              state_reg, state_next;
   logic [CORES-1:0]    to_send_reg, to_send_next;
   logic [CORES-1:0]    pending_reg, pending_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [1:0]          param_reg, param_next;
   logic [CID_W-1:0]    dest_reg, dest_next;
   logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
   logic                any_dirty_reg, any_dirty_next;
   logic                err_reg, err_next;
   logic                timeout_comb;

   logic [CORES-1:0]    ack_hit;
   logic [CORES-1:0]    dest_dec;
   logic [CORES-1:0]    pending_acked;
   logic                ack_good;
   logic                ack_bad;
   logic                handshake;

   // An ack is only legal from a core that has been probed and has not yet answered.
   generate
      for (genvar gi = 0; gi < CORES; gi++) begin : g_core
         assign ack_hit[gi]  = ack_valid_i && (ack_id_i == CID_W'(gi)) &&
                               pending_reg[gi] && !to_send_reg[gi];
         assign dest_dec[gi] = (dest_reg == CID_W'(gi));
      end
   endgenerate

   assign ack_good      = |ack_hit;
   assign ack_bad       = ack_valid_i && !ack_good;
   assign pending_acked = pending_reg & ~ack_hit;
   assign handshake     = (state_reg == ST_ISSUE) && b_ready_i;

   function automatic logic [CID_W-1:0] lowest_idx(input logic [CORES-1:0] m);
      lowest_idx = '0;
      for (int i = CORES - 1; i >= 0; i--) begin
         if (m[i]) lowest_idx = CID_W'(i);
      end
   endfunction

   always_comb begin
      state_next     = state_reg;
      to_send_next   = to_send_reg;
      pending_next   = pending_reg;
      addr_next      = addr_reg;
      param_next     = param_reg;
      dest_next      = dest_reg;
      wdog_next      = wdog_reg;
      any_dirty_next = any_dirty_reg;
      err_next       = err_reg;
      timeout_comb   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               addr_next      = start_addr_i;
               param_next     = start_param_i;
               to_send_next   = start_mask_i;
               pending_next   = start_mask_i;
               dest_next      = lowest_idx(start_mask_i);
               wdog_next      = '0;
               any_dirty_next = 1'b0;
               err_next       = 1'b0;
               state_next     = (start_mask_i == '0) ? ST_DONE : ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            pending_next   = pending_acked;
            any_dirty_next = any_dirty_reg | (ack_good && ack_data_i);
            err_next       = err_reg | ack_bad;
            if (ack_valid_i) wdog_next = '0;
            if (handshake) begin
               to_send_next = to_send_reg & ~dest_dec;
               dest_next    = lowest_idx(to_send_reg & ~dest_dec);
               if ((to_send_reg & ~dest_dec) == '0) begin
                  wdog_next  = '0;
                  state_next = (pending_acked == '0) ? ST_DONE : ST_WAIT_ACK;
               end
            end
         end

         ST_WAIT_ACK: begin
            pending_next   = pending_acked;
            any_dirty_next = any_dirty_reg | (ack_good && ack_data_i);
            err_next       = err_reg | ack_bad;
            if (pending_acked == '0) begin
               state_next = ST_DONE;
            end else if (ack_valid_i) begin
               wdog_next = '0;
            end else if (wdog_reg == '1) begin
               // Watchdog expiry abandons the round without a done pulse.
               timeout_comb = 1'b1;
               pending_next = '0;
               state_next   = ST_IDLE;
            end else begin
               wdog_next = wdog_reg + TIMEOUT_W'(1);
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= ST_IDLE;
         to_send_reg   <= '0;
         pending_reg   <= '0;
         addr_reg      <= '0;
         param_reg     <= '0;
         dest_reg      <= '0;
         wdog_reg      <= '0;
         any_dirty_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         to_send_reg   <= to_send_next;
         pending_reg   <= pending_next;
         addr_reg      <= addr_next;
         param_reg     <= param_next;
         dest_reg      <= dest_next;
         wdog_reg      <= wdog_next;
         any_dirty_reg <= any_dirty_next;
         err_reg       <= err_next;
      end
   end

   assign busy_o      = (state_reg != ST_IDLE);
   assign done_o      = (state_reg == ST_DONE);
   assign timeout_o   = timeout_comb;
   assign any_dirty_o = any_dirty_reg;
   assign err_o       = err_reg;
   assign pending_o   = pending_reg;
   assign b_opcode_o  = 3'd6;
   assign b_param_o   = param_reg;
   assign b_address_o = addr_reg;
   assign b_dest_o    = dest_reg;
   assign b_valid_o   = (state_reg == ST_ISSUE);

endmodule

// File: tb/tb_cpu64_l2_probe_sched.sv
// Self-checking bench for cpu64_l2_probe_sched: probe scoreboard plus directed round scenarios.
module tb_cpu64_l2_probe_sched;

   localparam int CORES  = 4;
   localparam int ADDR_W = 64;
   localparam int CID_W  = 2;

   typedef struct packed {
      logic [CID_W-1:0]  dest;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        param;
   } probe_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CORES-1:0]  start_mask;
   logic [ADDR_W-1:0] start_addr;
   logic [1:0]        start_param;
   logic              busy, done, timeout, any_dirty, err;
   logic [CORES-1:0]  pending;
   logic [2:0]        b_opcode;
   logic [1:0]        b_param;
   logic [ADDR_W-1:0] b_address;
   logic [CID_W-1:0]  b_dest;
   logic              b_valid;
   logic              b_ready;
   logic              ack_valid;
   logic [CID_W-1:0]  ack_id;
   logic              ack_data;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     done_cnt = 0;
   int     valid_cycles = 0;
   probe_t exp_q[$];

   cpu64_l2_probe_sched #(.CORES(CORES), .ADDR_W(ADDR_W), .TIMEOUT_W(10)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_mask_i (start_mask),
      .start_addr_i (start_addr),
      .start_param_i(start_param),
      .busy_o       (busy),
      .done_o       (done),
      .timeout_o    (timeout),
      .any_dirty_o  (any_dirty),
      .err_o        (err),
      .pending_o    (pending),
      .b_opcode_o   (b_opcode),
      .b_param_o    (b_param),
      .b_address_o  (b_address),
      .b_dest_o     (b_dest),
      .b_valid_o    (b_valid),
      .b_ready_i    (b_ready),
      .ack_valid_i  (ack_valid),
      .ack_id_i     (ack_id),
      .ack_data_i   (ack_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_round(input logic [CORES-1:0] mask, input logic [ADDR_W-1:0] addr,
                              input logic [1:0] param);
      probe_t p;
      start       = 1'b1;
      start_mask  = mask;
      start_addr  = addr;
      start_param = param;
      for (int i = 0; i < CORES; i++) begin
         if (mask[i]) begin
            p.dest  = CID_W'(i);
            p.addr  = addr;
            p.param = param;
            exp_q.push_back(p);
         end
      end
      $display("start mask=%b addr=0x%0h param=%0d", mask, addr, param);
      tick();
      start = 1'b0;
   endtask

   task automatic send_ack(input int id, input logic data);
      ack_valid = 1'b1;
      ack_id    = CID_W'(id);
      ack_data  = data;
      $display("ack id=%0d data=%0d", id, data);
      tick();
      ack_valid = 1'b0;
      ack_data  = 1'b0;
   endtask

   // Scoreboard: every accepted probe must match the next expected probe in order.
   always @(negedge clk) begin
      probe_t p;
      if (rst_n) begin
         if (b_valid) valid_cycles++;
         if (done) done_cnt++;
         if (b_valid && b_ready) begin
            $display("probe dest=%0d addr=0x%0h param=%0d op=%0d", b_dest, b_address, b_param, b_opcode);
            if (exp_q.size() == 0) begin
               check_eq("probe_unexpected", 1, 0);
            end else begin
               p = exp_q.pop_front();
               check_eq("probe_dest", 64'(b_dest), 64'(p.dest));
               check_eq("probe_addr", b_address, p.addr);
               check_eq("probe_param", 64'(b_param), 64'(p.param));
               check_eq("probe_opcode", 64'(b_opcode), 64'd6);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int d0;
      int v0;
      rst_n = 1'b0; start = 1'b0; start_mask = '0; start_addr = '0; start_param = '0;
      b_ready = 1'b0; ack_valid = 1'b0; ack_id = '0; ack_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 0);
      check_eq("rst_done", 64'(done), 0);
      check_eq("rst_valid", 64'(b_valid), 0);
      check_eq("rst_pending", 64'(pending), 0);
      check_eq("rst_err_dirty", {62'd0, err, any_dirty}, 0);
      rst_n = 1'b1;
      tick();

      // Round 1: two cores, back-to-back issue.
      b_ready = 1'b1;
      start_round(4'b1010, 64'h1000, 2'd2);
      check_eq("t1_valid_a", 64'(b_valid), 1);
      check_eq("t1_dest_a", 64'(b_dest), 1);
      tick();
      check_eq("t1_valid_b", 64'(b_valid), 1);
      check_eq("t1_dest_b", 64'(b_dest), 3);
      tick();
      check_eq("t1_valid_wait", 64'(b_valid), 0);
      check_eq("t1_pending", 64'(pending), 64'b1010);
      send_ack(1, 1'b0);
      check_eq("t1_pending_ack1", 64'(pending), 64'b1000);
      check_eq("t1_no_done", 64'(done), 0);
      send_ack(3, 1'b0);
      check_eq("t1_done", 64'(done), 1);
      check_eq("t1_pending_zero", 64'(pending), 0);
      tick();
      check_eq("t1_idle", 64'(busy), 0);
      check_eq("t1_done_cnt", 64'(done_cnt), 1);
      check_eq("t1_q_empty", 64'(exp_q.size()), 0);

      // Round 2: back-pressure on the first probe.
      b_ready = 1'b0;
      start_round(4'b0111, 64'hDEAD_BEEF_0000_0040, 2'd1);
      for (int i = 0; i < 3; i++) begin
         check_eq("t2_hold_valid", 64'(b_valid), 1);
         check_eq("t2_hold_dest", 64'(b_dest), 0);
         check_eq("t2_hold_addr", b_address, 64'hDEAD_BEEF_0000_0040);
         check_eq("t2_hold_param", 64'(b_param), 1);
         tick();
      end
      b_ready = 1'b1;
      repeat (3) tick();
      check_eq("t2_valid_wait", 64'(b_valid), 0);
      check_eq("t2_q_empty", 64'(exp_q.size()), 0);
      send_ack(2, 1'b0);
      send_ack(0, 1'b0);
      send_ack(1, 1'b0);
      check_eq("t2_done", 64'(done), 1);
      tick();

      // Round 3: empty mask completes without any probe.
      v0 = valid_cycles;
      start_round(4'b0000, 64'h0, 2'd0);
      check_eq("t3_done", 64'(done), 1);
      check_eq("t3_busy", 64'(busy), 1);
      tick();
      check_eq("t3_idle", 64'(busy), 0);
      check_eq("t3_no_valid", 64'(valid_cycles - v0), 0);

      // Round 4: unexpected ack and dirty ack.
      start_round(4'b0011, 64'h4440, 2'd0);
      repeat (2) tick();
      send_ack(2, 1'b0);
      check_eq("t4_err", 64'(err), 1);
      check_eq("t4_pending_kept", 64'(pending), 64'b0011);
      check_eq("t4_clean", 64'(any_dirty), 0);
      send_ack(0, 1'b1);
      check_eq("t4_dirty", 64'(any_dirty), 1);
      check_eq("t4_pending_ack0", 64'(pending), 64'b0010);
      send_ack(1, 1'b0);
      check_eq("t4_done", 64'(done), 1);
      tick();
      check_eq("t4_sticky", {62'd0, err, any_dirty}, 64'b11);

      // Round 5: watchdog expiry.
      d0 = done_cnt;
      start_round(4'b0001, 64'h5000, 2'd0);
      check_eq("t5_sticky_cleared", {62'd0, err, any_dirty}, 0);
      tick();
      n = 0;
      while (!timeout && n < 2000) begin
         tick();
         n++;
      end
      check_eq("t5_timeout_cycles", 64'(n), 64'd1023);
      check_eq("t5_timeout", 64'(timeout), 1);
      tick();
      check_eq("t5_idle", 64'(busy), 0);
      check_eq("t5_pending_cleared", 64'(pending), 0);
      check_eq("t5_timeout_pulse", 64'(timeout), 0);
      check_eq("t5_no_done", 64'(done_cnt - d0), 0);

      // Round 6: async reset mid-issue, then a fresh round.
      b_ready = 1'b0;
      start_round(4'b1111, 64'h2000, 2'd3);
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", 64'(b_valid), 0);
      check_eq("t6_rst_busy", 64'(busy), 0);
      check_eq("t6_rst_pending", 64'(pending), 0);
      check_eq("t6_rst_done", 64'(done), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      b_ready = 1'b1;
      start_round(4'b0100, 64'h3000, 2'd0);
      check_eq("t6_dest", 64'(b_dest), 2);
      tick();
      send_ack(2, 1'b1);
      check_eq("t6_done", 64'(done), 1);
      check_eq("t6_dirty", 64'(any_dirty), 1);
      tick();
      check_eq("t6_q_empty", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
